// File: rtl/garage_door_plant.sv
// Garage door mechanism model: turns motor drives into door position and limit switches,
// and flags illegal drive (both motors on) and stall (motor driven into a limit).
module garage_door_plant #(
  parameter int TRAVEL_TICKS = 100,
  parameter int STEP_DIV     = 4,
  parameter int STALL_CYC    = 8,
  parameter int POS_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DN_M,
  input  logic             clr_fault,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] position,
  output logic [2:0]       door_state,
  output logic             fault,
  output logic             stall
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    STOPPED = 3'd4,
    FAULT   = 3'd5
  } door_state_e;

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CNT_W = $clog2(STALL_CYC + 1);

  localparam logic [POS_W-1:0] TOP       = POS_W'(TRAVEL_TICKS);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYC);

  logic [POS_W-1:0] pos_q, pos_n;
  logic [PRE_W-1:0] pre_q, pre_n, pre_base;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             fault_q, fault_n;
  logic             stall_q, stall_n;
  logic             prev_up_q, prev_dn_q;
  door_state_e      state_q, state_n;

  logic up, dn, illegal, reversal, move_up, move_dn, stall_cond;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pos_n      = pos_q;
    pre_n      = '0;
    pre_base   = '0;
    cnt_n      = '0;
    stall_n    = 1'b0;
    fault_n    = fault_q;
    state_n    = STOPPED;

    up         = UP_M & ~DN_M;
    dn         = DN_M & ~UP_M;
    illegal    = UP_M & DN_M;
    reversal   = (up & prev_dn_q) | (dn & prev_up_q);
    move_up    = ~fault_q & up & (pos_q != TOP);
    move_dn    = ~fault_q & dn & (pos_q != '0);
    stall_cond = ~fault_q & ((up & (pos_q == TOP)) | (dn & (pos_q == '0)));

    if (illegal) begin
      fault_n = 1'b1;
    end else if (fault_q && clr_fault && !UP_M && !DN_M) begin
      fault_n = 1'b0;
    end

    // A reversal edge counts as the first prescaler tick of the new direction.
    if (move_up || move_dn) begin
      pre_base = reversal ? '0 : pre_q;
      if (pre_base == PRE_LAST) begin
        pre_n = '0;
        pos_n = move_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end else begin
        pre_n = pre_base + PRE_W'(1);
      end
    end

    if (stall_cond) begin
      cnt_n   = (cnt_q == STALL_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      stall_n = (cnt_n == STALL_MAX);
    end

    if (fault_n)                      state_n = FAULT;
    else if (up && (pos_n != TOP))    state_n = OPENING;
    else if (dn && (pos_n != '0))     state_n = CLOSING;
    else if (pos_n == '0)             state_n = CLOSED;
    else if (pos_n == TOP)            state_n = OPEN;
    else                              state_n = STOPPED;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pos_q     <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      stall_q   <= 1'b0;
      prev_up_q <= 1'b0;
      prev_dn_q <= 1'b0;
      state_q   <= CLOSED;
    end else begin
      pos_q     <= pos_n;
      pre_q     <= pre_n;
      cnt_q     <= cnt_n;
      fault_q   <= fault_n;
      stall_q   <= stall_n;
      prev_up_q <= up;
      prev_dn_q <= dn;
      state_q   <= state_n;
    end
  end

  assign position   = pos_q;
  assign UP_Max     = (pos_q == TOP);
  assign DN_Max     = (pos_q == '0);
  assign door_state = state_q;
  assign fault      = fault_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_garage_door_plant.sv
// Directed bench for garage_door_plant with TRAVEL_TICKS=10, STEP_DIV=4, STALL_CYC=3.
module tb_garage_door_plant;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UP_M = 1'b0;
  logic       DN_M = 1'b0;
  logic       clr_fault = 1'b0;
  logic       UP_Max, DN_Max, fault, stall;
  logic [7:0] position;
  logic [2:0] door_state;

  int n_cmp = 0;
  int n_mis = 0;

  garage_door_plant #(
    .TRAVEL_TICKS(10), .STEP_DIV(4), .STALL_CYC(3), .POS_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DN_M(DN_M), .clr_fault(clr_fault),
    .UP_Max(UP_Max), .DN_Max(DN_Max), .position(position),
    .door_state(door_state), .fault(fault), .stall(stall)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cmp_pos(input string name, input logic [7:0] exp);
    n_cmp++;
    if (position !== exp) begin
      n_mis++;
      $display("FAIL %s: position got %0d expected %0d", name, position, exp);
    end
  endtask

  task automatic cmp_state(input string name, input logic [2:0] exp);
    n_cmp++;
    if (door_state !== exp) begin
      n_mis++;
      $display("FAIL %s: door_state got %0d expected %0d", name, door_state, exp);
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    UP_M = 1'b0; DN_M = 1'b0; clr_fault = 1'b0;
    RST = 1'b0;
    #3;
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #22;
    RST = 1'b1;
    step(1);
    cmp_pos("reset_pos", 8'd0);
    cmp_bit("reset_dn_max", DN_Max, 1'b1);
    cmp_bit("reset_up_max", UP_Max, 1'b0);
    cmp_state("reset_state", 3'd0);
    cmp_bit("reset_fault", fault, 1'b0);
    cmp_bit("reset_stall", stall, 1'b0);
  endtask

  task automatic test_open();
    UP_M = 1'b1;
    step(1);
    cmp_state("open_e1_state", 3'd1);
    cmp_pos("open_e1_pos", 8'd0);
    step(2);
    cmp_pos("open_e3_pos", 8'd0);
    cmp_bit("open_e3_dn_max", DN_Max, 1'b1);
    step(1);
    cmp_pos("open_e4_pos", 8'd1);
    cmp_bit("open_e4_dn_max", DN_Max, 1'b0);
    step(35);
    cmp_pos("open_e39_pos", 8'd9);
    cmp_state("open_e39_state", 3'd1);
    cmp_bit("open_e39_up_max", UP_Max, 1'b0);
    step(1);
    cmp_pos("open_e40_pos", 8'd10);
    cmp_bit("open_e40_up_max", UP_Max, 1'b1);
    cmp_state("open_e40_state", 3'd2);
  endtask

  task automatic test_stall_top();
    step(2);
    cmp_bit("stall_e42", stall, 1'b0);
    step(1);
    cmp_bit("stall_e43", stall, 1'b1);
    cmp_pos("stall_e43_pos", 8'd10);
    step(1);
    cmp_bit("stall_hold", stall, 1'b1);
    UP_M = 1'b0;
    step(1);
    cmp_bit("stall_release", stall, 1'b0);
    cmp_state("stall_release_state", 3'd2);
  endtask

  task automatic test_fault();
    DN_M = 1'b1;
    step(1);
    cmp_state("close_e1_state", 3'd3);
    step(19);
    cmp_pos("close_to5_pos", 8'd5);
    cmp_state("close_to5_state", 3'd3);
    UP_M = 1'b1; DN_M = 1'b1; clr_fault = 1'b1;
    step(1);
    cmp_bit("illegal_fault", fault, 1'b1);
    cmp_state("illegal_state", 3'd5);
    cmp_pos("illegal_pos", 8'd5);
    UP_M = 1'b0;
    step(8);
    cmp_pos("fault_dn_pos", 8'd5);
    cmp_bit("fault_clr_ignored", fault, 1'b1);
    cmp_state("fault_dn_state", 3'd5);
    DN_M = 1'b0;
    step(1);
    cmp_bit("fault_cleared", fault, 1'b0);
    cmp_state("fault_cleared_state", 3'd4);
    cmp_pos("fault_cleared_pos", 8'd5);
    clr_fault = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    UP_M = 1'b1;
    step(10);
    cmp_pos("rev_up10_pos", 8'd2);
    UP_M = 1'b0; DN_M = 1'b1;
    step(1);
    cmp_state("rev_e1_state", 3'd3);
    cmp_pos("rev_e1_pos", 8'd2);
    step(2);
    cmp_pos("rev_e3_pos", 8'd2);
    step(1);
    cmp_pos("rev_e4_pos", 8'd1);
    cmp_state("rev_e4_state", 3'd3);
    step(4);
    cmp_pos("rev_bottom_pos", 8'd0);
    cmp_bit("rev_bottom_dn_max", DN_Max, 1'b1);
    cmp_state("rev_bottom_state", 3'd0);
    step(2);
    cmp_bit("stall_bot_e2", stall, 1'b0);
    step(1);
    cmp_bit("stall_bot_e3", stall, 1'b1);
    DN_M = 1'b0;
    step(1);
    cmp_bit("stall_bot_release", stall, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    UP_M = 1'b1;
    step(28);
    cmp_pos("async_pre_pos", 8'd7);
    RST = 1'b0;
    #1;
    cmp_pos("async_pos", 8'd0);
    cmp_bit("async_dn_max", DN_Max, 1'b1);
    cmp_state("async_state", 3'd0);
    UP_M = 1'b0;
    #1;
    RST = 1'b1;
    step(1);
    cmp_pos("async_after_pos", 8'd0);
  endtask

  initial begin
    test_reset();
    test_open();
    test_stall_top();
    test_fault();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
